// File: rtl/gv_pkg.sv
// Shared types and constants for the Guitar Villains multi-lane note engine.
package gv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } engine_state_e;

    localparam int HIT_PTS        = 1;
    localparam int BONUS_PTS      = 2;
    localparam int MISS_PTS       = -1;
    localparam int COMBO_INTERVAL = 4;
    localparam int COMBO_MAX      = 15;

endpackage

// File: rtl/note_lane.sv
// One note lane: scrolling LED shift register, button edge detect and press judging.
module note_lane
    import gv_pkg::*;
#(
    parameter int DEPTH    = 7,
    parameter int SONG_LEN = 32,
    parameter int PTR_W    = 6
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clr,
    input  logic                play,
    input  logic                beat,
    input  logic                button,
    input  logic [SONG_LEN-1:0] notes,
    input  logic [PTR_W-1:0]    ptr,
    output logic [DEPTH-1:0]    bits,
    output logic                hit_ev,
    output logic                miss_ev,
    output logic                bad_ev,
    output logic                empty_next
);
    logic             btn_q;
    logic             press_p0;
    logic             load_p0;
    logic [DEPTH-1:0] bits_d;

    assign press_p0 = play & button & ~btn_q;
    assign hit_ev   = press_p0 & bits[0];
    assign bad_ev   = press_p0 & ~bits[0];
    // A press in the beat cycle is judged first, so a hit note is never also a miss.
    assign miss_ev  = beat & bits[0] & ~press_p0;

    // Past the end of the song the one-hot select shifts out and loads 0.
    assign load_p0 = |(notes & (SONG_LEN'(1) << ptr));

    always_comb begin
        bits_d = bits;
        if (hit_ev) begin
            bits_d[0] = 1'b0;
        end
        if (beat) begin
            bits_d = {load_p0, bits_d[DEPTH-1:1]};
        end
        if (clr) begin
            bits_d = '0;
        end
    end

    assign empty_next = ~|bits_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            btn_q <= 1'b0;
            bits  <= '0;
        end else begin
            btn_q <= button;
            bits  <= bits_d;
        end
    end

endmodule

// File: rtl/multi_lane_note_engine.sv
// N-lane beat generator, note scroller, press judge and saturating scorer.
// Optional combo streak bonus is enabled by defining GV_COMBO_BONUS_EN.
module multi_lane_note_engine
    import gv_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int DEPTH    = 7,
    parameter int SONG_LEN = 32,
    parameter int SCORE_W  = 8,
    parameter int BEAT_W   = 23
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      run,
    input  logic                      pause,
    input  logic [BEAT_W-1:0]         diff_period,
    input  logic [LANES*SONG_LEN-1:0] song,
    input  logic [LANES-1:0]          button,
    output logic [LANES*DEPTH-1:0]    lane_disp,
    output logic                      beat_tick,
    output logic                      hit,
    output logic                      missed,
    output logic signed [SCORE_W-1:0] score,
    output logic                      is_neg,
    output logic [7:0]                num_hits,
    output logic [7:0]                num_misses,
    output logic [3:0]                combo,
    output logic                      finish
);
    localparam int PTR_W = $clog2(SONG_LEN + 1);
    localparam int ACC_W = SCORE_W + 4;
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (SCORE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    engine_state_e           state_q, state_d;
    logic                    in_play, start;
    logic [BEAT_W-1:0]       beat_cnt_q, period_m1;
    logic [PTR_W-1:0]        ptr_q;
    logic                    beat_p0, fin_p0;
    logic [LANES-1:0]        hit_v, miss_v, bad_v, empty_v;
    logic signed [ACC_W-1:0] delta_p0;
    logic [3:0]              nh_p0, nm_p0, combo_d, combo_q;

    function automatic logic signed [SCORE_W-1:0] sat_score(input logic signed [ACC_W-1:0] v);
        if (v > S_MAX) return $signed(S_MAX[SCORE_W-1:0]);
        if (v < S_MIN) return $signed(S_MIN[SCORE_W-1:0]);
        return $signed(v[SCORE_W-1:0]);
    endfunction

    function automatic logic [7:0] sat_cnt(input logic [7:0] c, input logic [3:0] n);
        logic [8:0] s;
        s = {1'b0, c} + {5'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PLAY;
                PLAY:    if (fin_p0) state_d = DONE;
                         else if (pause) state_d = HOLD;
                HOLD:    if (!pause) state_d = PLAY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_play = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE:    start   = run;
            PLAY:    in_play = 1'b1;
            default: ;
        endcase
    end

    // Compare with >= so a period shortened mid-song still wraps promptly.
    assign period_m1 = (diff_period == '0) ? '0 : diff_period - BEAT_W'(1);
    assign beat_p0   = in_play && (beat_cnt_q >= period_m1);
    assign fin_p0    = beat_p0 && (ptr_q >= PTR_W'(SONG_LEN - 1)) && (&empty_v);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_cnt_q <= '0;
            ptr_q      <= '0;
        end else if (start) begin
            beat_cnt_q <= '0;
            ptr_q      <= '0;
        end else if (in_play) begin
            beat_cnt_q <= beat_p0 ? '0 : beat_cnt_q + BEAT_W'(1);
            if (beat_p0 && (ptr_q < PTR_W'(SONG_LEN))) begin
                ptr_q <= ptr_q + PTR_W'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        note_lane #(
            .DEPTH   (DEPTH),
            .SONG_LEN(SONG_LEN),
            .PTR_W   (PTR_W)
        ) u_lane (
            .clk       (clk),
            .n_rst     (n_rst),
            .clr       (start),
            .play      (in_play),
            .beat      (beat_p0),
            .button    (button[l]),
            .notes     (song[l*SONG_LEN +: SONG_LEN]),
            .ptr       (ptr_q),
            .bits      (lane_disp[l*DEPTH +: DEPTH]),
            .hit_ev    (hit_v[l]),
            .miss_ev   (miss_v[l]),
            .bad_ev    (bad_v[l]),
            .empty_next(empty_v[l])
        );
    end

    // Lanes are folded in index order so same-cycle hits step the combo one at a time.
    always_comb begin
        delta_p0 = '0;
        nh_p0    = '0;
        nm_p0    = '0;
`ifdef GV_COMBO_BONUS_EN
        combo_d  = combo_q;
`else
        combo_d  = '0;
`endif
        for (int l = 0; l < LANES; l++) begin
            if (hit_v[l]) begin
                nh_p0 = nh_p0 + 4'd1;
`ifdef GV_COMBO_BONUS_EN
                if (combo_d != 4'(COMBO_MAX)) begin
                    combo_d  = combo_d + 4'd1;
                    delta_p0 = delta_p0 + (((int'(combo_d) % COMBO_INTERVAL) == 0) ?
                                           ACC_W'(BONUS_PTS) : ACC_W'(HIT_PTS));
                end else begin
                    delta_p0 = delta_p0 + ACC_W'(HIT_PTS);
                end
`else
                delta_p0 = delta_p0 + ACC_W'(HIT_PTS);
`endif
            end
            if (miss_v[l] || bad_v[l]) begin
                nm_p0    = nm_p0 + 4'd1;
                delta_p0 = delta_p0 + ACC_W'(MISS_PTS);
`ifdef GV_COMBO_BONUS_EN
                combo_d  = '0;
`endif
            end
        end
    end

    // Event stage -> registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            score      <= '0;
            num_hits   <= '0;
            num_misses <= '0;
            combo_q    <= '0;
            hit        <= 1'b0;
            missed     <= 1'b0;
            beat_tick  <= 1'b0;
            finish     <= 1'b0;
        end else if (start) begin
            score      <= '0;
            num_hits   <= '0;
            num_misses <= '0;
            combo_q    <= '0;
            hit        <= 1'b0;
            missed     <= 1'b0;
            beat_tick  <= 1'b0;
            finish     <= 1'b0;
        end else begin
            score      <= sat_score(ACC_W'(score) + delta_p0);
            num_hits   <= sat_cnt(num_hits, nh_p0);
            num_misses <= sat_cnt(num_misses, nm_p0);
            combo_q    <= combo_d;
            hit        <= (|hit_v) | (hit & ~beat_p0);
            missed     <= (|(miss_v | bad_v)) | (missed & ~beat_p0);
            beat_tick  <= beat_p0;
            finish     <= fin_p0;
        end
    end

    assign is_neg = score[SCORE_W-1];
    assign combo  = combo_q;

endmodule

// File: doc/multi_lane_note_engine.md
Name: multi_lane_note_engine

Overview:
Parametrised successor to the two-lane run/scoring core of the Guitar Villains game. Handles N note lanes of configurable display depth and song length:
- generates the beat from a difficulty period;
- scrolls song notes toward the hit position;
- judges per-lane button presses;
- keeps saturating signed score, hit/miss counters and finish detection.

Sits between the mode FSM (run/pause), the song store and the display mux.

Parameters:
LANES, 2, number of note lanes/buttons (1..8)
DEPTH, 7, LEDs per lane; index 0 is the hit position
SONG_LEN, 32, notes per lane in the song
SCORE_W, 8, signed score width
BEAT_W, 23, beat-period counter width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
run  in  1  high while mode is RUN or PAUSE; low = quit/idle
pause  in  1  freeze beat and judging while high
diff_period  in  BEAT_W  clocks per beat; 0 treated as 1
song  in  LANES*SONG_LEN  lane L note k at bit L*SONG_LEN+k
button  in  LANES  raw synchronised lane buttons, active high
lane_disp  out  LANES*DEPTH  lane L LEDs at [L*DEPTH +: DEPTH]
beat_tick  out  1  one-cycle pulse per beat
hit  out  1  high from a hit until next beat_tick
missed  out  1  high from a miss/bad press until next beat_tick
score  out  SCORE_W  signed, saturating
is_neg  out  1  score < 0
num_hits  out  8  saturating at 255
num_misses  out  8  saturating at 255
combo  out  4  current streak (0 when feature is off)
finish  out  1  one-cycle pulse when the song completes

Behaviour:
- Reset (async, n_rst=0): all outputs 0; state IDLE; lanes, song pointer ptr and beat counter 0.
- States:
  - IDLE: run=1 -> PLAY. On entry, clear score, counters, combo, lanes, ptr and beat counter.
  - PLAY: pause=1 -> HOLD.
  - HOLD: pause=0 -> PLAY. Counter, lanes and judging are all frozen; button edges are ignored.
  - DONE: entered on the finish condition; lanes are frozen.
  - From any state, run=0 -> IDLE next cycle. Score and counters hold their values until the next start.
- Beat: the counter increments in PLAY only. When it reaches max(diff_period,1)-1, it wraps to 0 and beat_tick=1 for that cycle. There is no beat_tick in HOLD or DONE.
- Scroll on beat_tick, per lane:
  - bit0 is discarded; bits shift down by one.
  - bit DEPTH-1 loads song[L*SONG_LEN+ptr] while ptr<SONG_LEN, else 0.
  - ptr increments, saturating at SONG_LEN.
- Miss: on beat_tick, each lane whose pre-shift bit0=1 (note not hit) is a miss: score -1, num_misses +1.
- Press: internal rising-edge detect on button[L], PLAY only. Judged against the current bit0.
  - bit0=1: hit. Clear bit0, score +1, num_hits +1.
  - bit0=0: bad press. Score -1, num_misses +1.
- Same-cycle events:
  - Press and beat_tick together: the press is judged first against pre-shift bit0. A hit clears the note, so it is not also a miss.
  - Multiple lanes sum their deltas in one cycle; counters add the event count.
  - All arithmetic is computed at SCORE_W+4 bits, then clamped to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1].
- hit/missed flags: set by the events above, cleared on the next beat_tick. A set in the same cycle as that beat_tick wins over the clear.
- Finish: ptr==SONG_LEN and all lane bits 0 after a scroll -> finish pulses 1 cycle, state -> DONE.
- Outputs are registered; one cycle of latency from the event to score/counters.

Optional Feature:
GV_COMBO_BONUS_EN
- Defined:
  - combo increments on each hit and clears on any miss or bad press. It saturates at 15.
  - A hit that makes combo a multiple of 4 adds +2 instead of +1.
- Undefined: combo is tied to 0 and every hit adds +1.

Decomposition:
- Package gv_pkg:
  - engine state enum (IDLE, PLAY, HOLD, DONE);
  - score delta constants HIT_PTS=1, BONUS_PTS=2, MISS_PTS=-1;
  - combo bonus interval 4.
- Sub-module note_lane, instantiated LANES times: DEPTH shift register, button edge detect, hit/miss/bad-press event outputs.
- The top level owns the beat counter, ptr, FSM and score/counter accumulation.

Test Plan:
1. diff_period=4, song lane0=1 at k=0, all else 0, no presses -> beat_tick every 4 clocks. Note reaches bit0 after DEPTH=7 beats. On beat 8: missed=1, score=-1 (0xFF), num_misses=1.
2. Same song, press button[0] while lane0 bit0=1 -> hit=1, score=1, num_hits=1, no miss on the next beat. Then press again with bit0=0 -> score=0, num_misses=1.
3. Press coinciding with beat_tick while bit0=1 -> counts only as a hit, score=+1.
4. pause=1 for 20 clocks mid-song -> lane_disp, score and beat counter unchanged, presses ignored. After release the beat resumes where it left off.
5. SONG_LEN=4, all notes in all lanes hit -> finish pulses exactly once after the last scroll empties the lanes, num_hits=8. With GV_COMBO_BONUS_EN, score=10.
6. Drive 130 misses on SCORE_W=8 -> score saturates at -128, is_neg=1. Assert n_rst mid-run -> all outputs 0 asynchronously.
